life_grid_seq: RTL and testbench
================================

Name: life_grid_seq

Overview:
- Upstream sequencer for the array of life_col4 columns. It drives the per-column write port (write_enb/val/row) to seed or clear the grid.
- It then gates the column enable for a requested number of generations.
- Each column's write_enb is this block's write_enb ANDed with its col_sel bit. val, row and enable are broadcast to all columns.

Parameters:
- NCOLS, 4, number of columns in the grid.
- NROWS, 4, cells per column (life_col4 = 4).
- ROW_W, 2, width of row index; must satisfy 2**ROW_W >= NROWS.
- GEN_W, 8, width of gen_count request.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  column pattern offered.
- load_ready  out  1  block accepts a column pattern this cycle.
- load_data  in  NROWS  pattern; bit r = value for row r.
- clear  in  1  request to zero the whole grid.
- start  in  1  request to run generations (level, sampled in IDLE).
- gen_count  in  GEN_W  generations to run; sampled with start.
- write_enb  out  1  write strobe to columns.
- val  out  1  cell value written.
- row  out  ROW_W  row being written.
- col_sel  out  NCOLS  one-hot column target (all ones during clear).
- enable  out  1  column evolve enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of a run.
- gen_total  out  16  total enabled cycles since reset, wraps at 2^16.

Behaviour:
- All outputs registered.
- While reset is low, every output is 0, state = IDLE and col_ptr = 0.
- load_ready rises on the first clock edge after reset goes high.
- States: IDLE, LOAD, CLEAR, RUN, DONE.
- IDLE:
  - load_ready = 1.
  - Priority when requests coincide: load handshake > clear > start.
  - A lower-priority request is not latched; the requester holds it.
- LOAD:
  - Entered on load_valid & load_ready at edge k; load_data captured at that edge.
  - After edges k .. k+NROWS-1: write_enb = 1, row = 0 .. NROWS-1, val = load_data[row], col_sel = onehot(col_ptr), load_ready = 0.
  - After edge k+NROWS: write_enb = 0, state = IDLE, load_ready = 1.
  - col_ptr increments, wrapping NCOLS-1 -> 0.
- CLEAR:
  - Same row walk as LOAD, with val = 0 and col_sel = all ones (NROWS cycles).
  - Resets col_ptr to 0.
- RUN:
  - start in IDLE at edge k with gen_count = N > 0 -> enable = 1 for exactly N cycles (after edges k .. k+N-1).
  - gen_total increments every enabled cycle.
- DONE:
  - After edge k+N: enable = 0, done = 1 for one cycle.
  - Next edge returns to IDLE.
  - start with gen_count = 0 goes straight to DONE: done pulses, enable never asserts.
- Invariant: write_enb and enable are never high in the same cycle.
- enable = 0 in every state except RUN.
- Inputs other than reset are ignored while busy.
- Reset asserted mid-LOAD/RUN:
  - All outputs drop to 0 immediately (asynchronously).
  - The partial load is abandoned and col_ptr returns to 0.
- row is held at 0 when write_enb = 0.
- Internal generation counter is GEN_W bits. gen_total is 16 bits and wraps silently.

Test Plan:
- Reset/idle: hold reset low 2 cycles, release -> all outputs 0 during reset; next edge load_ready = 1, busy = 0.
- Seed full column: load_data = 4'b1011, load_valid 1 cycle -> 4 cycles write_enb = 1, row 0,1,2,3, val 1,1,0,1, col_sel = 4'b0001; then load_ready = 1. A second load targets col_sel = 4'b0010. A fifth load wraps to col_sel = 4'b0001.
- Run: start with gen_count = 5 -> enable high exactly 5 cycles, done pulses 1 cycle after, gen_total = 5. Repeat with gen_count = 0 -> done pulse, no enable, gen_total unchanged.
- Clear then run against a life_col4 instance: seed 4'b1111 into column 0, clear -> alive_col = 0. Run 3 -> alive_col stays 0.
- Priority/ignore: load_valid, clear and start high in the same IDLE cycle -> LOAD taken. start pulsed during LOAD -> ignored. Held start is served after LOAD completes.
- Async reset mid-run: gen_count = 10, assert reset after 4 enabled cycles -> enable drops without a clock edge. After release: col_ptr = 0, gen_total = 0, no done pulse.

Source files
------------

// File: rtl/life_grid_seq.sv
// life_grid_seq: sequencer for an array of life_col4 columns.
// Seeds columns one row at a time, clears the whole grid, and gates the
// column evolve enable for a requested number of generations.
// Ports:
//   clk, reset (async, active-low)
//   load_valid/load_ready/load_data : column pattern handshake (bit r -> row r)
//   clear                           : zero the whole grid
//   start/gen_count                 : run gen_count generations
//   write_enb/val/row/col_sel       : column write port (col_sel all ones on clear)
//   enable                          : column evolve enable
//   busy/done                       : status, done pulses once at end of a run
//   gen_total                       : enabled cycles since reset, wraps at 2^16
module life_grid_seq #(
  parameter int unsigned NCOLS = 4,
  parameter int unsigned NROWS = 4,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [NROWS-1:0] load_data,
  input  logic             clear,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_count,
  output logic             write_enb,
  output logic             val,
  output logic [ROW_W-1:0] row,
  output logic [NCOLS-1:0] col_sel,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [15:0]      gen_total
);

  localparam int unsigned PTR_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned TOT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   col_ptr_q, col_ptr_d;
  logic [NROWS-1:0]   data_q, data_d;
  logic [GEN_W-1:0]   gen_cnt_q, gen_cnt_d;
  logic               load_ready_q, load_ready_d;
  logic               write_enb_q, write_enb_d;
  logic               val_q, val_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [NCOLS-1:0]   col_sel_q, col_sel_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TOT_W-1:0]   gen_total_q, gen_total_d;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      col_ptr_q    <= '0;
      data_q       <= '0;
      gen_cnt_q    <= '0;
      load_ready_q <= 1'b0;
      write_enb_q  <= 1'b0;
      val_q        <= 1'b0;
      row_q        <= '0;
      col_sel_q    <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      gen_total_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_ptr_q    <= col_ptr_d;
      data_q       <= data_d;
      gen_cnt_q    <= gen_cnt_d;
      load_ready_q <= load_ready_d;
      write_enb_q  <= write_enb_d;
      val_q        <= val_d;
      row_q        <= row_d;
      col_sel_q    <= col_sel_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      gen_total_q  <= gen_total_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    col_ptr_d   = col_ptr_q;
    data_d      = data_q;
    gen_cnt_d   = gen_cnt_q;
    write_enb_d = 1'b0;
    val_d       = 1'b0;
    row_d       = '0;
    col_sel_d   = '0;
    enable_d    = 1'b0;
    done_d      = 1'b0;
    // gen_total counts cycles in which enable was actually high
    gen_total_d = gen_total_q + TOT_W'(enable_q);

    case (state_q)
      S_IDLE: begin
        // Requests are only honoured once load_ready is up after reset
        if (load_ready_q) begin
          if (load_valid) begin
            state_d     = S_LOAD;
            data_d      = load_data;
            write_enb_d = 1'b1;
            val_d       = load_data[0];
            col_sel_d   = NCOLS'(1) << col_ptr_q;
          end else if (clear) begin
            state_d     = S_CLEAR;
            write_enb_d = 1'b1;
            col_sel_d   = '1;
            col_ptr_d   = '0;
          end else if (start) begin
            if (gen_count == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_RUN;
              enable_d  = 1'b1;
              gen_cnt_d = gen_count - GEN_W'(1);
            end
          end
        end
      end
      S_LOAD, S_CLEAR: begin
        if (row_q == ROW_W'(NROWS - 1)) begin
          state_d = S_IDLE;
          if (state_q == S_LOAD) begin
            col_ptr_d = (col_ptr_q == PTR_W'(NCOLS - 1)) ? '0 : col_ptr_q + PTR_W'(1);
          end
        end else begin
          write_enb_d = 1'b1;
          row_d       = row_q + ROW_W'(1);
          val_d       = (state_q == S_LOAD) ? data_q[row_d] : 1'b0;
          col_sel_d   = col_sel_q;
        end
      end
      S_RUN: begin
        // gen_cnt_q holds the enabled cycles still owed after this one
        if (gen_cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          enable_d  = 1'b1;
          gen_cnt_d = gen_cnt_q - GEN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  assign load_ready = load_ready_q;
  assign write_enb  = write_enb_q;
  assign val        = val_q;
  assign row        = row_q;
  assign col_sel    = col_sel_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gen_total  = gen_total_q;

endmodule

// File: tb/tb_life_grid_seq.sv
// Testbench for life_grid_seq: directed vector table, hand-written reset and
// column-wrap sequences, then random requests checked against a
// transaction-level model that expands each accepted request into the
// expected per-cycle output records.
module tb_life_grid_seq;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  load_data;
  logic        clear;
  logic        start;
  logic [7:0]  gen_count;
  logic        write_enb;
  logic        val;
  logic [1:0]  row;
  logic [3:0]  col_sel;
  logic        enable;
  logic        busy;
  logic        done;
  logic [15:0] gen_total;

  int checks;
  int errors;

  life_grid_seq #(
    .NCOLS(4), .NROWS(4), .ROW_W(2), .GEN_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .clear      (clear),
    .start      (start),
    .gen_count  (gen_count),
    .write_enb  (write_enb),
    .val        (val),
    .row        (row),
    .col_sel    (col_sel),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .gen_total  (gen_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        load_ready;
    logic        write_enb;
    logic        val;
    logic [1:0]  row;
    logic [3:0]  col_sel;
    logic        enable;
    logic        busy;
    logic        done;
    logic [15:0] gen_total;
  } obs_t;

  typedef struct {
    logic       lv;
    logic [3:0] ld;
    logic       clr;
    logic       st;
    logic [7:0] gc;
    obs_t       exp;
  } vec_t;

  function automatic obs_t o_idle(input logic [15:0] gt);
    return {1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, gt};
  endfunction

  function automatic obs_t o_wr(input logic [1:0] r, input logic v, input logic [3:0] cs,
                                input logic [15:0] gt);
    return {1'b0, 1'b1, v, r, cs, 1'b0, 1'b1, 1'b0, gt};
  endfunction

  function automatic obs_t o_en(input logic [15:0] gt);
    return {1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, gt};
  endfunction

  function automatic obs_t o_dn(input logic [15:0] gt);
    return {1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, gt};
  endfunction

  function automatic vec_t mkv(input logic lv, input logic [3:0] ld, input logic clr,
                               input logic st, input logic [7:0] gc, input obs_t exp);
    vec_t v;
    v.lv = lv; v.ld = ld; v.clr = clr; v.st = st; v.gc = gc; v.exp = exp;
    return v;
  endfunction

  function automatic obs_t sample();
    return {load_ready, write_enb, val, row, col_sel, enable, busy, done, gen_total};
  endfunction

  task automatic chk(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual {rdy,we,val,row,sel,en,busy,done,tot}=%b,%b,%b,%0d,%b,%b,%b,%b,%0d required %b,%b,%b,%0d,%b,%b,%b,%b,%0d",
               name, act.load_ready, act.write_enb, act.val, act.row, act.col_sel, act.enable,
               act.busy, act.done, act.gen_total, exp.load_ready, exp.write_enb, exp.val,
               exp.row, exp.col_sel, exp.enable, exp.busy, exp.done, exp.gen_total);
    end
  endtask

  // Drive one cycle of inputs, then check the outputs produced by that edge
  task automatic cyc(input logic i_lv, input logic [3:0] i_ld, input logic i_clr,
                     input logic i_st, input logic [7:0] i_gc, input obs_t exp,
                     input string name);
    load_valid = i_lv;
    load_data  = i_ld;
    clear      = i_clr;
    start      = i_st;
    gen_count  = i_gc;
    @(posedge clk);
    #1;
    chk(name, exp);
  endtask

  vec_t        tbl [27];
  obs_t        exp_q [$];
  obs_t        e;
  int          m_col;
  logic [15:0] m_gt;
  logic        r_lv, r_clr, r_st;
  logic [3:0]  r_ld;
  logic [7:0]  r_gc;
  logic [3:0]  oh;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    load_valid = 1'b0; load_data = 4'h0; clear = 1'b0; start = 1'b0; gen_count = 8'h0;

    // Reset held two cycles: every output low
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset_low[%0d]", i), '0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset", o_idle(16'd0));

    // Directed vector table
    tbl[0]  = mkv(1, 4'b1011, 0, 0, 0, o_wr(2'd0, 1'b1, 4'b0001, 16'd0));
    tbl[1]  = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd1, 1'b1, 4'b0001, 16'd0));
    tbl[2]  = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd2, 1'b0, 4'b0001, 16'd0));
    tbl[3]  = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd3, 1'b1, 4'b0001, 16'd0));
    tbl[4]  = mkv(0, 4'b0000, 0, 0, 0, o_idle(16'd0));
    tbl[5]  = mkv(1, 4'b0110, 1, 1, 3, o_wr(2'd0, 1'b0, 4'b0010, 16'd0));
    tbl[6]  = mkv(0, 4'b0000, 1, 1, 3, o_wr(2'd1, 1'b1, 4'b0010, 16'd0));
    tbl[7]  = mkv(0, 4'b0000, 1, 1, 3, o_wr(2'd2, 1'b1, 4'b0010, 16'd0));
    tbl[8]  = mkv(0, 4'b0000, 1, 1, 3, o_wr(2'd3, 1'b0, 4'b0010, 16'd0));
    tbl[9]  = mkv(0, 4'b0000, 1, 1, 3, o_idle(16'd0));
    tbl[10] = mkv(0, 4'b0000, 1, 1, 3, o_wr(2'd0, 1'b0, 4'b1111, 16'd0));
    tbl[11] = mkv(0, 4'b0000, 0, 1, 3, o_wr(2'd1, 1'b0, 4'b1111, 16'd0));
    tbl[12] = mkv(0, 4'b0000, 0, 1, 3, o_wr(2'd2, 1'b0, 4'b1111, 16'd0));
    tbl[13] = mkv(0, 4'b0000, 0, 1, 3, o_wr(2'd3, 1'b0, 4'b1111, 16'd0));
    tbl[14] = mkv(0, 4'b0000, 0, 1, 3, o_idle(16'd0));
    tbl[15] = mkv(0, 4'b0000, 0, 1, 3, o_en(16'd0));
    tbl[16] = mkv(0, 4'b0000, 0, 0, 0, o_en(16'd1));
    tbl[17] = mkv(0, 4'b0000, 0, 0, 0, o_en(16'd2));
    tbl[18] = mkv(0, 4'b0000, 0, 0, 0, o_dn(16'd3));
    tbl[19] = mkv(0, 4'b0000, 0, 0, 0, o_idle(16'd3));
    tbl[20] = mkv(0, 4'b0000, 0, 1, 0, o_dn(16'd3));
    tbl[21] = mkv(0, 4'b0000, 0, 0, 0, o_idle(16'd3));
    tbl[22] = mkv(1, 4'b1111, 0, 0, 0, o_wr(2'd0, 1'b1, 4'b0001, 16'd3));
    tbl[23] = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd1, 1'b1, 4'b0001, 16'd3));
    tbl[24] = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd2, 1'b1, 4'b0001, 16'd3));
    tbl[25] = mkv(0, 4'b0000, 0, 0, 0, o_wr(2'd3, 1'b1, 4'b0001, 16'd3));
    tbl[26] = mkv(0, 4'b0000, 0, 0, 0, o_idle(16'd3));
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].lv, tbl[i].ld, tbl[i].clr, tbl[i].st, tbl[i].gc, tbl[i].exp,
          $sformatf("tbl[%0d]", i));
    end

    // Async reset in the middle of a 10-generation run
    cyc(0, 4'h0, 0, 1, 8'd10, o_en(16'd3), "run10_en0");
    for (int i = 1; i < 4; i++) begin
      cyc(0, 4'h0, 0, 0, 8'd0, o_en(16'(3 + i)), $sformatf("run10_en%0d", i));
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_drop", '0);
    @(posedge clk);
    #1;
    chk("async_reset_hold", '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("async_reset_release", o_idle(16'd0));
    cyc(0, 4'h0, 0, 0, 8'd0, o_idle(16'd0), "no_done_after_reset");

    // Five loads: column pointer restarts at 0 and wraps after the fourth
    for (int j = 0; j < 5; j++) begin
      r_ld = 4'(j * 3 + 5);
      oh   = 4'b0001 << (j % 4);
      cyc(1, r_ld, 0, 0, 8'd0, o_wr(2'd0, r_ld[0], oh, 16'd0), $sformatf("wrap%0d_r0", j));
      for (int r = 1; r < 4; r++) begin
        cyc(0, 4'h0, 0, 0, 8'd0, o_wr(2'(r), r_ld[r], oh, 16'd0),
            $sformatf("wrap%0d_r%0d", j, r));
      end
      cyc(0, 4'h0, 0, 0, 8'd0, o_idle(16'd0), $sformatf("wrap%0d_idle", j));
    end

    // Random requests against the transaction model
    m_col = 1;
    m_gt  = 16'd0;
    for (int i = 0; i < 2500; i++) begin
      r_lv  = ($urandom_range(0, 3) == 0);
      r_ld  = 4'($urandom);
      r_clr = ($urandom_range(0, 9) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_gc  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 25)) : 8'($urandom_range(0, 5));
      if (exp_q.size() == 0) begin
        // Block is idle: these inputs are the ones sampled on the next edge
        if (r_lv) begin
          oh = 4'b0001 << m_col;
          for (int r = 0; r < 4; r++) exp_q.push_back(o_wr(2'(r), r_ld[r], oh, m_gt));
          exp_q.push_back(o_idle(m_gt));
          m_col = (m_col + 1) % 4;
        end else if (r_clr) begin
          for (int r = 0; r < 4; r++) exp_q.push_back(o_wr(2'(r), 1'b0, 4'b1111, m_gt));
          exp_q.push_back(o_idle(m_gt));
          m_col = 0;
        end else if (r_st) begin
          for (int n = 0; n < int'(r_gc); n++) exp_q.push_back(o_en(m_gt + 16'(n)));
          m_gt = m_gt + 16'(r_gc);
          exp_q.push_back(o_dn(m_gt));
          exp_q.push_back(o_idle(m_gt));
        end
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : o_idle(m_gt);
      cyc(r_lv, r_ld, r_clr, r_st, r_gc, e, $sformatf("rand[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
